// File: rtl/led_count_pkg.sv
// Shared types and constants for the LED counting sequencer.
package led_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic FREQ_1HZ  = 1'b1;
  localparam logic FREQ_10HZ = 1'b0;

  localparam int DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/led_count_ctrl_if.sv
// Button/divider/LED signal bundle of led_count_ctrl; slave = controller side.
interface led_count_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             btn_start;
  logic             btn_stop;
  logic             btn_speed;
  logic             dir;
  logic             tick_in;
  logic             sel_freq;
  logic             div_rst;
  logic [CNT_W-1:0] led;
  logic             running;
  logic             done;

  modport slave (
    input  btn_start, btn_stop, btn_speed, dir, tick_in,
    output sel_freq, div_rst, led, running, done
  );

  modport master (
    output btn_start, btn_stop, btn_speed, dir, tick_in,
    input  sel_freq, div_rst, led, running, done
  );
endinterface

// File: rtl/led_count_ctrl_btn_debounce.sv
// Level debouncer: output follows input only after DB_CYCLES stable cycles.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (din != stable_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) stable_d = din;
      else                             cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout = stable_q;
endmodule

// File: rtl/led_count_ctrl.sv
// Start/stop sequencer for the LED counter and clock divider.
// Define LED_COUNT_CTRL_DEBOUNCE_EN to debounce the three buttons.
module led_count_ctrl
  import led_count_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int CNT_MAX   = 255,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst,
  led_count_ctrl_if.slave      bus
);
  localparam int NIN = 4;  // {tick, speed, stop, start}
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  logic [NIN-1:0] raw, sync1_q, sync2_q, lvl, lvl_q, press_q, press_d;

  assign raw = {bus.tick_in, bus.btn_speed, bus.btn_stop, bus.btn_start};

`ifdef LED_COUNT_CTRL_DEBOUNCE_EN
  for (genvar i = 0; i < NIN - 1; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_in (clk_in),
      .rst    (rst),
      .din    (sync2_q[i]),
      .dout   (lvl[i])
    );
  end
  assign lvl[NIN-1] = sync2_q[NIN-1];
`else
  assign lvl = sync2_q;
`endif

  // Registered edge pulse gives the 3-cycle raw-to-action latency.
  always_comb press_d = lvl & ~lvl_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl;
      press_q <= press_d;
    end
  end

  logic start_p, stop_p, speed_p, tick_p;
  assign {tick_p, speed_p, stop_p, start_p} = press_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] led_q, led_d, nxt;
  logic             dir_q, dir_d, sel_q, sel_d;
  logic             running_q, running_d, done_q, done_d, div_rst_q, div_rst_d;

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    sel_d   = sel_q;
    nxt     = dir_q ? led_q + 1'b1 : led_q - 1'b1;
    if (speed_p) sel_d = ~sel_q;
    case (state_q)
      IDLE: begin
        led_d = '0;
        if (start_p && !stop_p) begin
          state_d = RUN;
          dir_d   = bus.dir;
          led_d   = bus.dir ? '0 : MAX_V;
        end
      end
      RUN: begin
        if (tick_p) led_d = nxt;
        // A terminal tick beats a simultaneous stop.
        if (tick_p && nxt == (dir_q ? MAX_V : '0)) state_d = DONE;
        else if (stop_p)                           state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_p) begin
          state_d = IDLE;
          led_d   = '0;
        end else if (start_p) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop_p) begin
          state_d = IDLE;
          led_d   = '0;
        end else if (start_p) begin
          state_d = RUN;
          dir_d   = bus.dir;
          led_d   = bus.dir ? '0 : MAX_V;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
    div_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      led_q     <= '0;
      dir_q     <= 1'b1;
      sel_q     <= FREQ_1HZ;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      div_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      dir_q     <= dir_d;
      sel_q     <= sel_d;
      running_q <= running_d;
      done_q    <= done_d;
      div_rst_q <= div_rst_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.sel_freq = sel_q;
  assign bus.div_rst  = div_rst_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_led_count_ctrl.sv
// Self-checking bench for led_count_ctrl with CNT_MAX = 5, no debounce.
module tb_led_count_ctrl;
  localparam int CNT_W = 8;
  localparam int MAX   = 5;

  // action mask bits
  localparam int A_START = 1, A_STOP = 2, A_SPEED = 4, A_TICK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_count_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  led_count_ctrl #(.CNT_W(CNT_W), .CNT_MAX(MAX), .DB_CYCLES(4)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: mode 0 idle, 1 counting, 2 paused, 3 finished.
  int m_mode, m_cnt;
  bit m_dir, m_sel;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_dir = 1'b1; m_sel = 1'b1;
  endtask

  task automatic model_step(input int a, input bit d);
    bit s, p, t;
    s = (a & A_START) != 0;
    p = (a & A_STOP)  != 0;
    t = (a & A_TICK)  != 0;
    if ((a & A_SPEED) != 0) m_sel = !m_sel;
    if (m_mode == 1) begin
      if (t) m_cnt = m_dir ? m_cnt + 1 : m_cnt - 1;
      if (t && m_cnt == (m_dir ? MAX : 0)) m_mode = 3;
      else if (p)                          m_mode = 2;
    end else if (m_mode == 2) begin
      if (p)      begin m_mode = 0; m_cnt = 0; end
      else if (s) m_mode = 1;
    end else begin
      if (p && m_mode == 3) begin m_mode = 0; m_cnt = 0; end
      else if (s && !p) begin m_mode = 1; m_dir = d; m_cnt = d ? 0 : MAX; end
    end
  endtask

  task automatic chk(input string nm, input int led, input bit run, input bit dn,
                     input bit sel, input bit drst);
    checks++;
    if (ifc.led !== CNT_W'(led) || ifc.running !== run || ifc.done !== dn ||
        ifc.sel_freq !== sel || ifc.div_rst !== drst) begin
      errors++;
      $display("FAIL %s: got led=%0d run=%b done=%b sel=%b drst=%b, want led=%0d run=%b done=%b sel=%b drst=%b",
               nm, ifc.led, ifc.running, ifc.done, ifc.sel_freq, ifc.div_rst,
               led, run, dn, sel, drst);
    end
  endtask

  task automatic chk_model(input string nm);
    chk(nm, m_cnt, m_mode == 1, m_mode == 3, m_sel, m_mode != 1);
  endtask

  // Raise the selected inputs for 2 cycles, release, let the pipeline settle.
  task automatic do_act(input int a, input bit d);
    @(negedge clk);
    ifc.dir       = d;
    ifc.btn_start = (a & A_START) != 0;
    ifc.btn_stop  = (a & A_STOP)  != 0;
    ifc.btn_speed = (a & A_SPEED) != 0;
    ifc.tick_in   = (a & A_TICK)  != 0;
    repeat (2) @(negedge clk);
    ifc.btn_start = 1'b0; ifc.btn_stop = 1'b0;
    ifc.btn_speed = 1'b0; ifc.tick_in  = 1'b0;
    repeat (5) @(negedge clk);
    model_step(a, d);
  endtask

  typedef struct {
    int act; bit dir; int led; bit run; bit dn; bit sel; bit drst;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int a, input bit d, input int led, input bit run,
                     input bit dn, input bit sel, input bit drst);
    vec_t v;
    v.act = a; v.dir = d; v.led = led; v.run = run; v.dn = dn; v.sel = sel; v.drst = drst;
    tbl.push_back(v);
  endtask

  initial begin
    int old;
    // up run to terminal
    add(A_STOP, 1, 0, 0, 0, 1, 1);           // stop ignored in idle
    add(A_START, 1, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add(A_TICK, 1, i, 1, 0, 1, 0);
    add(A_TICK, 1, 5, 0, 1, 1, 1);
    add(A_STOP, 1, 0, 0, 0, 1, 1);
    // pause / resume
    add(A_START, 1, 0, 1, 0, 1, 0);
    add(A_TICK, 1, 1, 1, 0, 1, 0);
    add(A_TICK, 1, 2, 1, 0, 1, 0);
    add(A_STOP, 1, 2, 0, 0, 1, 1);
    add(A_TICK, 1, 2, 0, 0, 1, 1);
    add(A_START, 1, 2, 1, 0, 1, 0);
    add(A_TICK, 1, 3, 1, 0, 1, 0);
    add(A_STOP, 1, 3, 0, 0, 1, 1);
    add(A_STOP, 1, 0, 0, 0, 1, 1);
    // down run
    add(A_START, 0, 5, 1, 0, 1, 0);
    for (int i = 4; i >= 1; i--) add(A_TICK, 0, i, 1, 0, 1, 0);
    add(A_TICK, 0, 0, 0, 1, 1, 1);
    add(A_START, 0, 5, 1, 0, 1, 0);
    add(A_START | A_STOP, 0, 5, 0, 0, 1, 1);  // stop wins
    add(A_START, 1, 5, 1, 0, 1, 0);           // resume keeps latched dir
    add(A_TICK, 1, 4, 1, 0, 1, 0);
    add(A_SPEED, 0, 4, 1, 0, 0, 0);
    add(A_STOP, 0, 4, 0, 0, 0, 1);
    add(A_STOP, 0, 0, 0, 0, 0, 1);
    // tick+stop reaching terminal
    add(A_START, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(A_TICK, 1, i, 1, 0, 0, 0);
    add(A_TICK | A_STOP, 1, 5, 0, 1, 0, 1);
    add(A_SPEED, 1, 5, 0, 1, 1, 1);
    add(A_STOP, 1, 0, 0, 0, 1, 1);
    // tick+stop not terminal -> pause with tick applied
    add(A_START, 1, 0, 1, 0, 1, 0);
    add(A_TICK | A_STOP, 1, 1, 0, 0, 1, 1);
    add(A_STOP, 1, 0, 0, 0, 1, 1);

    ifc.btn_start = 0; ifc.btn_stop = 0; ifc.btn_speed = 0;
    ifc.tick_in = 0; ifc.dir = 1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 0, 0, 0, 1, 1);

    foreach (tbl[i]) begin
      do_act(tbl[i].act, tbl[i].dir);
      chk($sformatf("vec%0d", i), tbl[i].led, tbl[i].run, tbl[i].dn, tbl[i].sel, tbl[i].drst);
    end

    // exact tick latency: raw edge sampled at edge n, led moves at n+3
    do_act(A_START, 1);
    chk_model("lat_start");
    @(negedge clk);
    old = m_cnt;
    ifc.tick_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("tick_lat_n2", old, 1, 0, m_sel, 0);
    @(posedge clk);
    #1 chk("tick_lat_n3", old + 1, 1, 0, m_sel, 0);
    @(negedge clk); ifc.tick_in = 1'b0;
    repeat (4) @(negedge clk);
    model_step(A_TICK, 1);

    // exact speed latency, div_rst stays low
    @(negedge clk);
    ifc.btn_speed = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("speed_lat_n2", m_cnt, 1, 0, m_sel, 0);
    @(posedge clk);
    #1 chk("speed_lat_n3", m_cnt, 1, 0, !m_sel, 0);
    repeat (6) @(negedge clk);
    chk("speed_held_once", m_cnt, 1, 0, !m_sel, 0);
    ifc.btn_speed = 1'b0;
    repeat (4) @(negedge clk);
    model_step(A_SPEED, 1);

    // async reset mid-run
    do_act(A_TICK, 1);
    chk_model("pre_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", 0, 0, 0, 1, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("post_reset", 0, 0, 0, 1, 1);

    // randomized actions against the reference model
    for (int i = 0; i < 200; i++) begin
      int a;
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) a = A_TICK;
      do_act(a, 1'($urandom_range(0, 1)));
      chk_model($sformatf("rand%0d_a%0d", i, a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
